// File: rtl/imem_program_loader.sv
// imem_program_loader: boot loader that streams a length-prefixed, checksummed image into instruction memory.
module imem_program_loader #(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH = 128,
  parameter int SKIP_LOAD = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  load_req,
  output logic [ADDR_WIDTH-1:0] imem_address,
  output logic [31:0]           imem_data,
  output logic                  imem_wren,
  output logic                  core_reset,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERROR} state_t;
  localparam state_t INIT = (SKIP_LOAD != 0) ? RUN : LEN;
  localparam logic [ADDR_WIDTH:0] ONE = 1;
  state_t state, state_d;
  logic [ADDR_WIDTH:0] n;
  logic [1:0] byte_cnt;
  logic [7:0] sum;
  logic [23:0] part;
  logic accept, last_word;
  assign accept = rx_valid && rx_ready;
  assign last_word = (words_loaded + ONE) == n;
  always_comb begin
    state_d = state;
    case (state)
      LEN:     if (accept) state_d = (int'(rx_data) > DEPTH) ? ERROR : (rx_data == 8'd0) ? CSUM : DATA;
      DATA:    if (accept && byte_cnt == 2'd3 && last_word) state_d = CSUM;
      CSUM:    if (accept) state_d = (rx_data == sum) ? RUN : ERROR;
      default: if (load_req) state_d = LEN;
    endcase
  end
  // Status outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= INIT;
      rx_ready <= INIT != RUN;
      core_reset <= INIT != RUN;
      error <= 1'b0;
      imem_wren <= 1'b0;
      imem_address <= '0;
      imem_data <= '0;
      words_loaded <= '0;
      n <= '0;
      byte_cnt <= '0;
      sum <= '0;
      part <= '0;
    end else begin
      state <= state_d;
      rx_ready <= state_d inside {LEN, DATA, CSUM};
      core_reset <= state_d != RUN;
      error <= state_d == ERROR;
      imem_wren <= 1'b0;
      if (state == LEN && accept) begin
        n <= (ADDR_WIDTH+1)'(rx_data);
        sum <= '0;
        byte_cnt <= '0;
      end
      if (state == DATA && accept) begin
        sum <= sum + rx_data;
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt != 2'd3) part[{byte_cnt, 3'b000} +: 8] <= rx_data;
        else begin
          imem_wren <= 1'b1;
          imem_address <= words_loaded[ADDR_WIDTH-1:0];
          imem_data <= {rx_data, part};
          words_loaded <= words_loaded + ONE;
        end
      end
      if ((state == RUN || state == ERROR) && load_req) words_loaded <= '0;
    end
  end
endmodule
